mc_pc_ir_unit: RTL and testbench

- Fetch/PC stage of the multicycle MIPS core; sits between the unified instruction/data memory and the controller.
- Holds PC, IR and MDR. Evaluates the PC-load condition from the controller's PCWrite / PCWriteCondBeq / PCWriteCondBne strobes and the ALU zero flag.
- Selects the next PC from the PCSrc mux and drives the memory address via IorD.
- Decodes IR fields, including the 6-bit opc consumed by the controller, and keeps fetch/branch statistics counters.

---
 rtl/mc_pc_ir_unit.sv | 114 +++++++++++
 tb/tb_mc_pc_ir_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mc_pc_ir_unit.sv
// Fetch/PC stage of the multicycle MIPS core: holds PC, IR and MDR, resolves
// the PC-load condition, drives the memory address and keeps fetch statistics.
module mc_pc_ir_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PCWrite,
    input  logic             PCWriteCondBeq,
    input  logic             PCWriteCondBne,
    input  logic             IorD,
    input  logic             IRWrite,
    input  logic [1:0]       PCSrc,
    input  logic             zero,
    input  logic [31:0]      alu_result,
    input  logic [31:0]      alu_out,
    input  logic [31:0]      reg_a,
    input  logic [31:0]      mem_rdata,
    output logic [31:0]      mem_addr,
    output logic [31:0]      pc,
    output logic [31:0]      ir,
    output logic [5:0]       opc,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [15:0]      imm16,
    output logic [5:0]       func,
    output logic [31:0]      mdr,
    output logic [31:0]      inst_pc,
    output logic             misalign,
    output logic [CNT_W-1:0] inst_count,
    output logic [CNT_W-1:0] br_taken_count
);

    logic [31:0]      r_pc;
    logic [31:0]      r_ir;
    logic [31:0]      r_mdr;
    logic [31:0]      r_inst_pc;
    logic             r_misalign;
    logic [CNT_W-1:0] r_inst_count;
    logic [CNT_W-1:0] r_br_taken_count;

    logic             w_br_taken;
    logic             w_pc_load;
    logic [31:0]      w_next_pc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // A taken conditional branch counts even when PCWrite is also asserted.
    assign w_br_taken = (PCWriteCondBeq & zero) | (PCWriteCondBne & ~zero);
    assign w_pc_load  = PCWrite | w_br_taken;

    always_comb begin
        w_next_pc = alu_result;
        unique case (PCSrc)
            2'b00: w_next_pc = alu_result;
            2'b01: w_next_pc = alu_out;
            2'b10: w_next_pc = {r_pc[31:28], r_ir[25:0], 2'b00};
            2'b11: w_next_pc = reg_a;
            default: w_next_pc = alu_result;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc             <= RESET_PC;
            r_ir             <= 32'h0;
            r_mdr            <= 32'h0;
            r_inst_pc        <= RESET_PC;
            r_misalign       <= 1'b0;
            r_inst_count     <= '0;
            r_br_taken_count <= '0;
        end else begin
            r_mdr <= mem_rdata;
            if (w_pc_load) begin
                // Misaligned targets are forced onto a word boundary and flagged.
                r_pc <= {w_next_pc[31:2], 2'b00};
                if (w_next_pc[1:0] != 2'b00) begin
                    r_misalign <= 1'b1;
                end
            end
            if (IRWrite) begin
                r_ir         <= mem_rdata;
                r_inst_pc    <= r_pc;
                r_inst_count <= sat_inc(r_inst_count);
            end
            if (w_br_taken) begin
                r_br_taken_count <= sat_inc(r_br_taken_count);
            end
        end
    end

    assign mem_addr       = IorD ? alu_out : r_pc;
    assign pc             = r_pc;
    assign ir             = r_ir;
    assign opc            = r_ir[31:26];
    assign rs             = r_ir[25:21];
    assign rt             = r_ir[20:16];
    assign rd             = r_ir[15:11];
    assign imm16          = r_ir[15:0];
    assign func           = r_ir[5:0];
    assign mdr            = r_mdr;
    assign inst_pc        = r_inst_pc;
    assign misalign       = r_misalign;
    assign inst_count     = r_inst_count;
    assign br_taken_count = r_br_taken_count;

endmodule

// File: tb/tb_mc_pc_ir_unit.sv
// Directed bench for mc_pc_ir_unit: a vector table of consecutive cycles plus
// hand-written sequences for sticky misalign, reset and counter saturation.
module tb_mc_pc_ir_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCWrite, PCWriteCondBeq, PCWriteCondBne, IorD, IRWrite, zero;
    logic [1:0]  PCSrc;
    logic [31:0] alu_result, alu_out, reg_a, mem_rdata;

    logic [31:0] mem_addr, pc, ir, mdr, inst_pc;
    logic [5:0]  opc, func;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic        misalign;
    logic [15:0] inst_count, br_taken_count;

    logic [31:0] s_mem_addr, s_pc, s_ir, s_mdr, s_inst_pc;
    logic [5:0]  s_opc, s_func;
    logic [4:0]  s_rs, s_rt, s_rd;
    logic [15:0] s_imm16;
    logic        s_misalign;
    logic [3:0]  s_inst_count, s_br_taken_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mc_pc_ir_unit #(.RESET_PC(32'h0), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .PCWrite(PCWrite), .PCWriteCondBeq(PCWriteCondBeq),
        .PCWriteCondBne(PCWriteCondBne), .IorD(IorD), .IRWrite(IRWrite), .PCSrc(PCSrc),
        .zero(zero), .alu_result(alu_result), .alu_out(alu_out), .reg_a(reg_a),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .pc(pc), .ir(ir), .opc(opc),
        .rs(rs), .rt(rt), .rd(rd), .imm16(imm16), .func(func), .mdr(mdr),
        .inst_pc(inst_pc), .misalign(misalign), .inst_count(inst_count),
        .br_taken_count(br_taken_count)
    );

    mc_pc_ir_unit #(.RESET_PC(32'h0), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .PCWrite(PCWrite), .PCWriteCondBeq(PCWriteCondBeq),
        .PCWriteCondBne(PCWriteCondBne), .IorD(IorD), .IRWrite(IRWrite), .PCSrc(PCSrc),
        .zero(zero), .alu_result(alu_result), .alu_out(alu_out), .reg_a(reg_a),
        .mem_rdata(mem_rdata), .mem_addr(s_mem_addr), .pc(s_pc), .ir(s_ir), .opc(s_opc),
        .rs(s_rs), .rt(s_rt), .rd(s_rd), .imm16(s_imm16), .func(s_func), .mdr(s_mdr),
        .inst_pc(s_inst_pc), .misalign(s_misalign), .inst_count(s_inst_count),
        .br_taken_count(s_br_taken_count)
    );

    typedef struct {
        logic        pw, beq, bne, zr, iord, irw;
        logic [1:0]  pcsrc;
        logic [31:0] alu_result, alu_out, reg_a, mem_rdata;
        logic [31:0] exp_addr, exp_pc, exp_ir, exp_ipc;
        logic        exp_mis;
        logic [31:0] exp_icnt, exp_brc;
    } vec_t;

    vec_t vec[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pw, input logic beq, input logic bne, input logic zr,
                         input logic iord, input logic irw, input logic [1:0] src,
                         input logic [31:0] ar, input logic [31:0] ao,
                         input logic [31:0] ra, input logic [31:0] md);
        PCWrite = pw; PCWriteCondBeq = beq; PCWriteCondBne = bne; zero = zr;
        IorD = iord; IRWrite = irw; PCSrc = src;
        alu_result = ar; alu_out = ao; reg_a = ra; mem_rdata = md;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //             pw beq bne z iord irw src  alu_result     alu_out       reg_a         mem_rdata      addr           pc             ir             inst_pc  mis icnt brc
        vec[0]  = '{1, 0, 0, 0, 0, 1, 2'b00, 32'h4,         32'h0,        32'h0,        32'h8C22_0004, 32'h0,         32'h4,         32'h8C22_0004, 32'h0,  0, 1, 0};
        vec[1]  = '{1, 0, 0, 0, 0, 0, 2'b00, 32'h8,         32'h0,        32'h0,        32'h0,         32'h4,         32'h8,         32'h8C22_0004, 32'h0,  0, 1, 0};
        vec[2]  = '{0, 1, 0, 1, 0, 0, 2'b01, 32'h0,         32'h20,       32'h0,        32'h0,         32'h8,         32'h20,        32'h8C22_0004, 32'h0,  0, 1, 1};
        vec[3]  = '{1, 0, 0, 0, 0, 0, 2'b00, 32'h8,         32'h0,        32'h0,        32'h0,         32'h20,        32'h8,         32'h8C22_0004, 32'h0,  0, 1, 1};
        vec[4]  = '{0, 1, 0, 0, 0, 0, 2'b01, 32'h0,         32'h20,       32'h0,        32'h0,         32'h8,         32'h8,         32'h8C22_0004, 32'h0,  0, 1, 1};
        vec[5]  = '{0, 0, 1, 0, 0, 0, 2'b01, 32'h0,         32'h20,       32'h0,        32'h0,         32'h8,         32'h20,        32'h8C22_0004, 32'h0,  0, 1, 2};
        vec[6]  = '{1, 0, 0, 0, 0, 0, 2'b00, 32'h8,         32'h0,        32'h0,        32'h0,         32'h20,        32'h8,         32'h8C22_0004, 32'h0,  0, 1, 2};
        vec[7]  = '{0, 0, 1, 1, 0, 0, 2'b01, 32'h0,         32'h20,       32'h0,        32'h0,         32'h8,         32'h8,         32'h8C22_0004, 32'h0,  0, 1, 2};
        vec[8]  = '{0, 1, 1, 0, 0, 0, 2'b01, 32'h0,         32'h20,       32'h0,        32'h0,         32'h8,         32'h20,        32'h8C22_0004, 32'h0,  0, 1, 3};
        vec[9]  = '{1, 0, 0, 0, 0, 1, 2'b00, 32'h1000_0004, 32'h0,        32'h0,        32'h0800_0040, 32'h20,        32'h1000_0004, 32'h0800_0040, 32'h20, 0, 2, 3};
        vec[10] = '{1, 0, 0, 0, 0, 0, 2'b10, 32'h0,         32'h0,        32'h0,        32'h0,         32'h1000_0004, 32'h1000_0100, 32'h0800_0040, 32'h20, 0, 2, 3};
        vec[11] = '{1, 0, 0, 0, 0, 0, 2'b11, 32'h0,         32'h0,        32'h44,       32'h0,         32'h1000_0100, 32'h44,        32'h0800_0040, 32'h20, 0, 2, 3};
        vec[12] = '{1, 0, 0, 0, 0, 0, 2'b11, 32'h0,         32'h0,        32'h46,       32'h0,         32'h44,        32'h44,        32'h0800_0040, 32'h20, 1, 2, 3};
        vec[13] = '{0, 0, 0, 0, 1, 0, 2'b00, 32'h0,         32'h80,       32'h0,        32'hDEAD_BEEF, 32'h80,        32'h44,        32'h0800_0040, 32'h20, 1, 2, 3};
        vec[14] = '{0, 0, 0, 0, 0, 0, 2'b00, 32'h0,         32'h80,       32'h0,        32'h1234_5678, 32'h44,        32'h44,        32'h0800_0040, 32'h20, 1, 2, 3};
        vec[15] = '{1, 1, 0, 1, 0, 0, 2'b01, 32'h0,         32'h100,      32'h0,        32'h0,         32'h44,        32'h100,       32'h0800_0040, 32'h20, 1, 2, 4};

        rst = 1'b1;
        idle();
        tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_mdr", mdr, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_misalign", {31'h0, misalign}, 32'h0);
        chk("rst_inst_count", {16'h0, inst_count}, 32'h0);
        chk("rst_br_count", {16'h0, br_taken_count}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(vec[i].pw, vec[i].beq, vec[i].bne, vec[i].zr, vec[i].iord, vec[i].irw,
                  vec[i].pcsrc, vec[i].alu_result, vec[i].alu_out, vec[i].reg_a, vec[i].mem_rdata);
            #1;
            chk($sformatf("v%0d_mem_addr", i), mem_addr, vec[i].exp_addr);
            tick();
            chk($sformatf("v%0d_pc", i), pc, vec[i].exp_pc);
            chk($sformatf("v%0d_ir", i), ir, vec[i].exp_ir);
            chk($sformatf("v%0d_inst_pc", i), inst_pc, vec[i].exp_ipc);
            chk($sformatf("v%0d_mdr", i), mdr, vec[i].mem_rdata);
            chk($sformatf("v%0d_misalign", i), {31'h0, misalign}, {31'h0, vec[i].exp_mis});
            chk($sformatf("v%0d_inst_count", i), {16'h0, inst_count}, vec[i].exp_icnt);
            chk($sformatf("v%0d_br_count", i), {16'h0, br_taken_count}, vec[i].exp_brc);
        end

        // misalign is sticky through idle cycles
        idle();
        repeat (5) tick();
        chk("mis_sticky", {31'h0, misalign}, 32'h1);
        chk("idle_pc_hold", pc, 32'h100);

        // reset in the middle of an instruction wins over every strobe
        rst = 1'b1;
        drive(1, 1, 0, 1, 0, 1, 2'b00, 32'h500, 32'h600, 32'h0, 32'hFFFF_FFFF);
        tick();
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_ir", ir, 32'h0);
        chk("midrst_misalign", {31'h0, misalign}, 32'h0);
        chk("midrst_inst_count", {16'h0, inst_count}, 32'h0);
        chk("midrst_br_count", {16'h0, br_taken_count}, 32'h0);
        rst = 1'b0;

        // fresh fetch after reset, then field decode of an R-type word
        drive(1, 0, 0, 0, 0, 1, 2'b00, 32'h4, 32'h0, 32'h0, 32'h014B_4820);
        #1;
        chk("fetch_mem_addr", mem_addr, 32'h0);
        tick();
        chk("fetch_pc", pc, 32'h4);
        chk("fetch_inst_pc", inst_pc, 32'h0);
        chk("dec_opc", {26'h0, opc}, 32'h0);
        chk("dec_rs", {27'h0, rs}, 32'd10);
        chk("dec_rt", {27'h0, rt}, 32'd11);
        chk("dec_rd", {27'h0, rd}, 32'd9);
        chk("dec_imm16", {16'h0, imm16}, 32'h4820);
        chk("dec_func", {26'h0, func}, 32'h20);
        drive(1, 0, 0, 0, 0, 1, 2'b00, 32'h8, 32'h0, 32'h0, 32'h8C22_0004);
        tick();
        chk("dec_lw_opc", {26'h0, opc}, 32'h23);
        chk("dec_lw_rs", {27'h0, rs}, 32'd1);
        chk("dec_lw_rt", {27'h0, rt}, 32'd2);
        chk("dec_lw_imm16", {16'h0, imm16}, 32'h4);
        chk("dec_lw_inst_pc", inst_pc, 32'h4);

        // saturation: 20 fetch + taken-branch cycles
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 0, 1, 0, 1, 2'b00, 32'(4 * (i + 1)), 32'h0, 32'h0, 32'h0);
            tick();
        end
        idle();
        chk("sat_inst_count", {28'h0, s_inst_count}, 32'd15);
        chk("sat_br_count", {28'h0, s_br_taken_count}, 32'd15);
        chk("wide_inst_count", {16'h0, inst_count}, 32'd20);
        chk("wide_br_count", {16'h0, br_taken_count}, 32'd20);
        chk("sat_pc", s_pc, 32'd80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
